// File: rtl/nf_instr_encoder.sv
`default_nettype none
// =============================================================================
// nf_instr_encoder : symbolic op -> RV32I word encoder with LI expansion
// Revision 1.0
// =============================================================================
module nf_instr_encoder (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_vld,
   output logic        req_rdy,
   input  logic [3:0]  req_op,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   output logic [31:0] instr,
   output logic        instr_vld,
   input  logic        instr_rdy,
   output logic        err
);

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_LI2  = 1'b1;

   localparam logic [3:0] c_OP_ADD  = 4'd0;
   localparam logic [3:0] c_OP_SUB  = 4'd1;
   localparam logic [3:0] c_OP_OR   = 4'd2;
   localparam logic [3:0] c_OP_SLLI = 4'd3;
   localparam logic [3:0] c_OP_ADDI = 4'd4;
   localparam logic [3:0] c_OP_LUI  = 4'd5;
   localparam logic [3:0] c_OP_BEQ  = 4'd6;
   localparam logic [3:0] c_OP_BNE  = 4'd7;
   localparam logic [3:0] c_OP_LI   = 4'd8;

   localparam logic [6:0] c_OPC_R  = 7'b0110011;
   localparam logic [6:0] c_OPC_I  = 7'b0010011;
   localparam logic [6:0] c_OPC_U  = 7'b0110111;
   localparam logic [6:0] c_OPC_B  = 7'b1100011;

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [31:0] r_instr;
   logic        r_instr_vld;
   logic        r_err;
   logic [4:0]  r_li_rd;
   logic [11:0] r_li_lo;

   logic [31:0] w_word;
   logic        w_emit;
   logic        w_illegal;
   logic        w_li2;
   logic        w_li_small;
   logic [19:0] w_li_hi;
   logic        w_out_free;
   logic        w_acc;
   logic        w_load_req;
   logic        w_load_li2;

   // (imm + 0x800) >> 12 reduces to the upper 20 bits plus the carry out of imm[11:0] + 0x800
   assign w_li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
   assign w_li_small = (req_imm[31:11] == {21{req_imm[11]}});

   always_comb begin
      w_word    = 32'd0;
      w_emit    = 1'b1;
      w_illegal = 1'b0;
      w_li2     = 1'b0;
      case (req_op)
         c_OP_ADD:  w_word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, c_OPC_R};
         c_OP_SUB:  w_word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, c_OPC_R};
         c_OP_OR:   w_word = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, c_OPC_R};
         c_OP_SLLI: w_word = {7'b0000000, req_imm[4:0], req_rs1, 3'b001, req_rd, c_OPC_I};
         c_OP_ADDI: w_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, c_OPC_I};
         c_OP_LUI:  w_word = {req_imm[31:12], req_rd, c_OPC_U};
         c_OP_BEQ:  w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                              req_imm[4:1], req_imm[11], c_OPC_B};
         c_OP_BNE:  w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                              req_imm[4:1], req_imm[11], c_OPC_B};
         c_OP_LI: begin
            if (w_li_small) begin
               w_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, c_OPC_I};
            end else begin
               w_word = {w_li_hi, req_rd, c_OPC_U};
               w_li2  = |req_imm[11:0];
            end
         end
         default: begin
            w_emit    = 1'b0;
            w_illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (w_acc && w_li2) w_state_nxt = c_ST_LI2;
         c_ST_LI2:  if (w_out_free)     w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_out_free = !r_instr_vld || instr_rdy;
      req_rdy    = (r_state == c_ST_IDLE) && w_out_free;
      w_acc      = req_vld && req_rdy;
      w_load_req = w_acc && w_emit;
      w_load_li2 = (r_state == c_ST_LI2) && w_out_free;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_instr     <= 32'd0;
         r_instr_vld <= 1'b0;
         r_err       <= 1'b0;
         r_li_rd     <= 5'd0;
         r_li_lo     <= 12'd0;
      end else begin
         r_err <= w_acc && w_illegal;
         if (w_load_req) begin
            r_instr     <= w_word;
            r_instr_vld <= 1'b1;
         end else if (w_load_li2) begin
            r_instr     <= {r_li_lo, r_li_rd, 3'b000, r_li_rd, c_OPC_I};
            r_instr_vld <= 1'b1;
         end else if (instr_rdy) begin
            r_instr_vld <= 1'b0;
         end
         if (w_acc && w_li2) begin
            r_li_rd <= req_rd;
            r_li_lo <= req_imm[11:0];
         end
      end
   end

   assign instr     = r_instr;
   assign instr_vld = r_instr_vld;
   assign err       = r_err;

endmodule
`default_nettype wire
